// File: rtl/watch_pkg.sv
// Shared constants, digit types and hour-to-display conversion for the watch time counter.
package watch_pkg;

    localparam int unsigned SEC_MAX    = 59;
    localparam int unsigned MIN_MAX    = 59;
    localparam int unsigned HR_MAX     = 23;
    localparam int unsigned HR_12_NOON = 12;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    typedef struct packed {
        bcd_t hr_tens;
        bcd_t hr_ones;
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
        logic pm;
        logic colon;
    } disp_t;

    // Internal hours are always 0-23; 12-hour mode maps 0 to 12 and 13-23 to 1-11.
    function automatic bcd2_t hr_to_bcd(input logic [4:0] hr, input logic mode_12h);
        logic [4:0] h;
        bcd2_t      r;
        h = hr;
        if (mode_12h) begin
            if (hr == 5'd0) begin
                h = 5'(HR_12_NOON);
            end else if (hr > 5'(HR_12_NOON)) begin
                h = hr - 5'(HR_12_NOON);
            end
        end
        if (h >= 5'd20) begin
            r.tens = 4'd2;
            r.ones = 4'(h - 5'd20);
        end else if (h >= 5'd10) begin
            r.tens = 4'd1;
            r.ones = 4'(h - 5'd10);
        end else begin
            r.tens = 4'd0;
            r.ones = h[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX; carry_out flags the wrapping increment.
module bcd_mod_counter
    import watch_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output bcd_t ones,
    output bcd_t tens,
    output logic carry_out
);

    localparam bcd_t MaxOnes = bcd_t'(MAX % 10);
    localparam bcd_t MaxTens = bcd_t'(MAX / 10);

    bcd_t ones_q, ones_d;
    bcd_t tens_q, tens_d;
    logic at_max;

    assign at_max = (ones_q == MaxOnes) && (tens_q == MaxTens);

    always_comb begin
        ones_d    = ones_q;
        tens_d    = tens_q;
        carry_out = 1'b0;
        if (clr) begin
            ones_d = '0;
            tens_d = '0;
        end else if (inc) begin
            if (at_max) begin
                ones_d    = '0;
                tens_d    = '0;
                carry_out = 1'b1;
            end else if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;

endmodule

// File: rtl/watch_time_counter.sv
// Time-of-day counter with set mode, 12/24-hour display and a registered BCD display stage.
module watch_time_counter
    import watch_pkg::*;
#(
    parameter int unsigned RESET_HOUR         = 0,
    parameter bit          SET_CLEARS_SECONDS = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1hz,
    input  logic set_mode,
    input  logic btn_min,
    input  logic btn_hr,
    input  logic mode_12h,
    output bcd_t sec_ones,
    output bcd_t sec_tens,
    output bcd_t min_ones,
    output bcd_t min_tens,
    output bcd_t hr_ones,
    output bcd_t hr_tens,
    output logic pm,
    output logic colon
);

    logic       set_q, set_d;
    logic       btn_min_q, btn_min_d;
    logic       btn_hr_q, btn_hr_d;
    logic       blink_q, blink_d;
    logic [4:0] hr_q, hr_d;
    disp_t      disp_q, disp_d;

    logic  run_tick, min_edge, hr_edge;
    logic  sec_inc, sec_clr, sec_carry;
    logic  min_inc, min_carry, hr_inc;
    bcd_t  sec_o, sec_t, min_o, min_t;
    bcd2_t hr_digits;

    assign run_tick = tick_1hz & ~set_mode;
    assign min_edge = btn_min & ~btn_min_q;
    assign hr_edge  = btn_hr & ~btn_hr_q;

    // Seconds are cleared on entry and held at zero for the whole set session.
    assign sec_inc = run_tick;
    assign sec_clr = set_mode & SET_CLEARS_SECONDS;
    assign min_inc = set_mode ? min_edge : sec_carry;
    assign hr_inc  = set_mode ? hr_edge : min_carry;

    bcd_mod_counter #(
        .MAX (SEC_MAX)
    ) u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_inc),
        .clr       (sec_clr),
        .ones      (sec_o),
        .tens      (sec_t),
        .carry_out (sec_carry)
    );

    bcd_mod_counter #(
        .MAX (MIN_MAX)
    ) u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (min_inc),
        .clr       (1'b0),
        .ones      (min_o),
        .tens      (min_t),
        .carry_out (min_carry)
    );

    always_comb begin
        hr_d      = hr_q;
        set_d     = set_mode;
        btn_min_d = btn_min;
        btn_hr_d  = btn_hr;
        blink_d   = blink_q ^ run_tick;
        if (hr_inc) begin
            hr_d = (hr_q == 5'(HR_MAX)) ? 5'd0 : hr_q + 5'd1;
        end
    end

    always_comb begin
        hr_digits       = hr_to_bcd(hr_q, mode_12h);
        disp_d          = '0;
        disp_d.hr_tens  = hr_digits.tens;
        disp_d.hr_ones  = hr_digits.ones;
        disp_d.min_tens = min_t;
        disp_d.min_ones = min_o;
        disp_d.sec_tens = sec_t;
        disp_d.sec_ones = sec_o;
        disp_d.pm       = (hr_q >= 5'(HR_12_NOON));
        disp_d.colon    = set_q | blink_q;
    end

    // Button history resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            hr_q      <= 5'(RESET_HOUR);
            set_q     <= 1'b0;
            btn_min_q <= 1'b1;
            btn_hr_q  <= 1'b1;
            blink_q   <= 1'b0;
            disp_q    <= '0;
        end else begin
            hr_q      <= hr_d;
            set_q     <= set_d;
            btn_min_q <= btn_min_d;
            btn_hr_q  <= btn_hr_d;
            blink_q   <= blink_d;
            disp_q    <= disp_d;
        end
    end

    assign sec_ones = disp_q.sec_ones;
    assign sec_tens = disp_q.sec_tens;
    assign min_ones = disp_q.min_ones;
    assign min_tens = disp_q.min_tens;
    assign hr_ones  = disp_q.hr_ones;
    assign hr_tens  = disp_q.hr_tens;
    assign pm       = disp_q.pm;
    assign colon    = disp_q.colon;

endmodule
